// File: rtl/axpy_update_if.sv
// Operand and result signals of the AXPY update unit, grouped for a single port.
interface axpy_update_if #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32
);
  localparam int W = no_of_units * element_width;

  // Handshake: start is a one-cycle request accepted only while busy is low.
  // read_again high for one cycle means the current x/p word is consumed and
  // the source must show the next word by the following CAPTURE.
  // result_mem_we_4 high for one cycle qualifies result_data_out/result_mem_counter.
  // done pulses once per accepted start.
  logic          start;
  logic [31:0]   total;
  logic [31:0]   alpha;
  logic          subtract;
  logic [W-1:0]  x_data_in;
  logic [W-1:0]  p_data_in;
  logic          read_again;
  logic          result_mem_we_4;
  logic [W-1:0]  result_data_out;
  logic [31:0]   result_mem_counter;
  logic          busy;
  logic          done;

  modport master (
    output start, total, alpha, subtract, x_data_in, p_data_in,
    input  read_again, result_mem_we_4, result_data_out, result_mem_counter, busy, done
  );

  modport slave (
    input  start, total, alpha, subtract, x_data_in, p_data_in,
    output read_again, result_mem_we_4, result_data_out, result_mem_counter, busy, done
  );
endinterface

// File: rtl/axpy_update_unit.sv
// Streaming r = x +/- alpha*p over Q16.16 lanes, one memory word every two cycles,
// with a two-stage multiply/accumulate pipeline and per-lane saturation.
module axpy_update_unit #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32
) (
  input  logic              clk,
  input  logic              reset,
  axpy_update_if.slave      bus,
  output logic [1:0]        dbg_state
);
  localparam int EW    = element_width;
  localparam int W     = no_of_units * EW;
  localparam int PW    = EW + 32;
  localparam int SW    = PW + 2;
  localparam int SHIFT = $clog2(no_of_units);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam logic signed [SW-1:0] MAXV = {{(SW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-EW+1){1'b1}}, {(EW-1){1'b0}}};

  logic [1:0]        state;
  logic [31:0]       n_words;
  logic [31:0]       alpha_q;
  logic              sub_q;
  logic [31:0]       rd_cnt;
  logic              busy_q;
  logic              done_q;

  // Stage 0: captured operands; stage 1: products; stage 2: result registers.
  logic              v0, v1, we_q;
  logic [W-1:0]      x0, p0, x1;
  logic [31:0]       idx0, idx1;
  logic signed [PW-1:0] prod1 [no_of_units];
  logic signed [PW-1:0] prod_n [no_of_units];
  logic [W-1:0]      res_n;
  logic [W-1:0]      res_q;
  logic [31:0]       cnt_q;

  logic signed [PW-1:0] alpha_ext;
  assign alpha_ext = {{(PW-32){alpha_q[31]}}, alpha_q};

  for (genvar l = 0; l < no_of_units; l++) begin : g_lane
    logic signed [PW-1:0] p_ext;
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] sh_ext;
    logic signed [SW-1:0] sum;
    logic                 unused_frac;

    assign p_ext     = {{(PW-EW){p0[l*EW+EW-1]}}, p0[l*EW +: EW]};
    assign prod_n[l] = alpha_ext * p_ext;

    // Arithmetic shift by 16 keeps the Q16.16 scale; fraction bits are dropped.
    assign sh_ext      = {{18{prod1[l][PW-1]}}, prod1[l][PW-1:16]};
    assign unused_frac = ^prod1[l][15:0];
    assign x_ext       = {{(SW-EW){x1[l*EW+EW-1]}}, x1[l*EW +: EW]};
    assign sum         = sub_q ? (x_ext - sh_ext) : (x_ext + sh_ext);

    assign res_n[l*EW +: EW] = (sum > MAXV) ? {1'b0, {(EW-1){1'b1}}} :
                               (sum < MINV) ? {1'b1, {(EW-1){1'b0}}} :
                               sum[EW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      n_words <= '0;
      alpha_q <= '0;
      sub_q   <= 1'b0;
      rd_cnt  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      we_q    <= 1'b0;
      x0      <= '0;
      p0      <= '0;
      x1      <= '0;
      idx0    <= '0;
      idx1    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < no_of_units; i++) prod1[i] <= '0;
    end else begin
      done_q <= 1'b0;
      v0     <= 1'b0;
      v1     <= v0;
      we_q   <= v1;

      if (v0) begin
        x1   <= x0;
        idx1 <= idx0;
        for (int i = 0; i < no_of_units; i++) prod1[i] <= prod_n[i];
      end

      // Result and index registers hold between write strobes.
      if (v1) begin
        res_q <= res_n;
        cnt_q <= idx1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            n_words <= bus.total >> SHIFT;
            alpha_q <= bus.alpha;
            sub_q   <= bus.subtract;
            rd_cnt  <= '0;
            if ((bus.total >> SHIFT) == 32'd0) begin
              done_q <= 1'b1;
            end else begin
              state  <= WAIT;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: state <= CAPTURE;
        CAPTURE: begin
          x0     <= bus.x_data_in;
          p0     <= bus.p_data_in;
          idx0   <= rd_cnt;
          v0     <= 1'b1;
          rd_cnt <= rd_cnt + 32'd1;
          state  <= (rd_cnt + 32'd1 < n_words) ? WAIT : DRAIN;
        end
        DRAIN: begin
          // The last strobe is visible while nothing is left behind it.
          if (we_q && !v0 && !v1) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_again         = (state == CAPTURE);
  assign bus.result_mem_we_4    = we_q;
  assign bus.result_data_out    = res_q;
  assign bus.result_mem_counter = cnt_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign dbg_state              = state;
endmodule

// File: tb/tb_axpy_update_unit.sv
// Bench for axpy_update_unit: table of uniform-lane passes, a random-lane pass,
// and hand-written zero-length, mid-pass reset and start-while-busy sequences.
module tb_axpy_update_unit;
  localparam int NU = 8;
  localparam int EW = 32;
  localparam int W  = NU * EW;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  axpy_update_if #(.no_of_units(NU), .element_width(EW)) bus ();

  axpy_update_unit #(.no_of_units(NU), .element_width(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Word source: the address advances on every read_again.
  logic [W-1:0] x_mem [0:7];
  logic [W-1:0] p_mem [0:7];
  int           rd_cnt_tb;
  int           pass_base;
  int           mem_idx;

  always @(posedge clk) begin
    if (reset) rd_cnt_tb <= 0;
    else if (bus.read_again) rd_cnt_tb <= rd_cnt_tb + 1;
  end

  assign mem_idx       = (rd_cnt_tb - pass_base) & 7;
  assign bus.x_data_in = x_mem[mem_idx[2:0]];
  assign bus.p_data_in = p_mem[mem_idx[2:0]];

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   cnt_q[$];
  int            n_ra, n_we, n_done;
  logic          prev_we = 1'b0;
  logic          done_prev_we = 1'b0;
  logic          done_busy = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] model_lane(input logic [31:0] a, input logic [EW-1:0] x,
                                               input logic [EW-1:0] p, input logic sub);
    longint prod, sh, s;
    prod = longint'($signed(a)) * longint'($signed(p));
    sh   = prod >>> 16;
    s    = sub ? (longint'($signed(x)) - sh) : (longint'($signed(x)) + sh);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // Scoreboard: every write strobe pops one expected word and index.
  always @(negedge clk) begin
    if (bus.read_again) n_ra++;
    if (bus.done) begin
      n_done++;
      done_prev_we = prev_we;
      done_busy    = bus.busy;
    end
    if (bus.result_mem_we_4) begin
      n_we++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {{(W-32){1'b0}}, bus.result_mem_counter}, {W{1'b1}});
      end else begin
        logic [W-1:0] e;
        logic [31:0]  ec;
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        check("wdata", bus.result_data_out, e);
        check("wcnt", {{(W-32){1'b0}}, bus.result_mem_counter}, {{(W-32){1'b0}}, ec});
      end
    end
    prev_we = bus.result_mem_we_4;
  end

  task automatic check_outputs_zero(input string nm);
    check({nm, "_read_again"}, bus.read_again, 0);
    check({nm, "_we"}, bus.result_mem_we_4, 0);
    check({nm, "_busy"}, bus.busy, 0);
    check({nm, "_done"}, bus.done, 0);
    check({nm, "_data"}, bus.result_data_out, 0);
    check({nm, "_counter"}, bus.result_mem_counter, 0);
  endtask

  task automatic drive_start(input logic [31:0] tot, input logic [31:0] al, input logic sb);
    @(posedge clk); #1;
    pass_base    = rd_cnt_tb;
    bus.total    = tot;
    bus.alpha    = al;
    bus.subtract = sb;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic run_pass(input string nm, input logic [31:0] tot, input logic [31:0] al,
                          input logic sb, input logic [31:0] xl, input logic [31:0] pl,
                          input logic [31:0] el, input bit rnd, input bit restart);
    int           nw;
    logic [W-1:0] xw, pw, ew, last;
    nw   = int'(tot >> 3);
    last = '0;
    for (int w = 0; w < nw; w++) begin
      for (int l = 0; l < NU; l++) begin
        if (rnd) begin
          xw[l*EW +: EW] = $urandom;
          pw[l*EW +: EW] = (l < 4) ? $urandom_range(0, 32'h0004_0000) : $urandom;
          ew[l*EW +: EW] = model_lane(al, xw[l*EW +: EW], pw[l*EW +: EW], sb);
        end else begin
          xw[l*EW +: EW] = xl;
          pw[l*EW +: EW] = pl;
          ew[l*EW +: EW] = el;
        end
      end
      x_mem[w] = xw;
      p_mem[w] = pw;
      exp_q.push_back(ew);
      cnt_q.push_back(w);
      last = ew;
    end
    n_ra = 0; n_we = 0; n_done = 0;
    drive_start(tot, al, sb);
    check({nm, "_busy_wait"}, bus.busy, 1);
    if (restart) begin
      bus.start    = 1'b1;
      bus.alpha    = 32'h0;
      bus.subtract = ~sb;
      bus.total    = 32'd64;
      @(posedge clk); #1;
      bus.start    = 1'b0;
    end
    for (int c = 0; c < 300 && n_done == 0; c++) @(posedge clk);
    if (n_done == 0) check({nm, "_done_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_n_done"}, n_done, 1);
    check({nm, "_n_we"}, n_we, nw);
    check({nm, "_n_read_again"}, n_ra, nw);
    check({nm, "_queue_left"}, exp_q.size(), 0);
    check({nm, "_done_after_we"}, done_prev_we, 1);
    check({nm, "_busy_with_done"}, done_busy, 0);
    check({nm, "_busy_after"}, bus.busy, 0);
    check({nm, "_hold_data"}, bus.result_data_out, last);
    check({nm, "_hold_counter"}, bus.result_mem_counter, nw - 1);
    exp_q.delete();
    cnt_q.delete();
  endtask

  typedef struct {
    logic [31:0] total;
    logic [31:0] alpha;
    logic        sub;
    logic [31:0] x;
    logic [31:0] p;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd16, 32'h0001_0000, 1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    vecs[1] = '{32'd8,  32'h0000_8000, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000};
    vecs[2] = '{32'd8,  32'h0001_0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    vecs[3] = '{32'd8,  32'h0001_0000, 1'b1, 32'h8001_0000, 32'h0002_0000, 32'h8000_0000};
    vecs[4] = '{32'd20, 32'hFFFF_0000, 1'b0, 32'h0005_0000, 32'h0002_0000, 32'h0003_0000};
    vecs[5] = '{32'd8,  32'hFFFF_8000, 1'b1, 32'hFFFF_0000, 32'h0003_0000, 32'h0000_8000};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.total    = '0;
    bus.alpha    = '0;
    bus.subtract = 1'b0;
    pass_base    = 0;
    for (int i = 0; i < 8; i++) begin
      x_mem[i] = '0;
      p_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_state", dbg_state, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++)
      run_pass($sformatf("vec%0d", v), vecs[v].total, vecs[v].alpha, vecs[v].sub,
               vecs[v].x, vecs[v].p, vecs[v].exp, 1'b0, 1'b0);

    run_pass("random", 32'd27, $urandom, 1'($urandom_range(0, 1)), '0, '0, '0, 1'b1, 1'b0);

    // Fewer than one word: done next cycle, no reads or writes.
    n_ra = 0; n_we = 0; n_done = 0;
    drive_start(32'd7, 32'h0001_0000, 1'b0);
    check("short_done_next", bus.done, 1);
    check("short_busy", bus.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("short_n_ra", n_ra, 0);
    check("short_n_we", n_we, 0);
    check("short_n_done", n_done, 1);

    // Reset during the third CAPTURE, with start asserted alongside it.
    for (int w = 0; w < 4; w++) begin
      x_mem[w] = {NU{32'h0001_0000}};
      p_mem[w] = {NU{32'h0001_0000}};
      exp_q.push_back({NU{32'h0002_0000}});
      cnt_q.push_back(w);
    end
    n_ra = 0; n_we = 0; n_done = 0;
    drive_start(32'd32, 32'h0001_0000, 1'b0);
    begin
      int caps;
      caps = 0;
      for (int c = 0; c < 50 && caps < 3; c++) begin
        @(posedge clk); #1;
        if (bus.read_again) caps++;
      end
      check("abort_reached_capture3", caps, 3);
    end
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    check_outputs_zero("abort");
    repeat (10) @(posedge clk);
    #1;
    check("abort_le2_writes", (n_we <= 2), 1);
    check("abort_no_done", n_done, 0);
    check("abort_idle", dbg_state, 0);
    exp_q.delete();
    cnt_q.delete();

    run_pass("after_abort", 32'd16, 32'h0001_0000, 1'b0, 32'h0001_0000, 32'h0002_0000,
             32'h0003_0000, 1'b0, 1'b0);

    // Second start during WAIT must not disturb the running pass.
    run_pass("restart", 32'd16, 32'h0002_0000, 1'b1, 32'h0004_0000, 32'h0001_0000,
             32'h0002_0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axpy_update_unit.md
AXPY_UPDATE_UNIT -- requirements
Module: axpy_update_unit

Interface
REQ-001 SHALL have parameter no_of_units, default 8, lanes per memory word.
REQ-002 SHALL have parameter element_width, default 32, signed Q16.16 lane width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a pass.
REQ-006 SHALL have port total  input  32  vector length in elements.
REQ-007 SHALL have port alpha  input  32  Q16.16 scalar.
REQ-008 SHALL have port subtract  input  1  1 computes x - alpha*p; 0 computes x + alpha*p.
REQ-009 SHALL have port x_data_in  input  256  8 lanes of X word; lane i at bits [32i+31:32i].
REQ-010 SHALL have port p_data_in  input  256  8 lanes of P word, same lane packing.
REQ-011 SHALL have port read_again  output  1  advance X/P read addresses by one.
REQ-012 SHALL have port result_mem_we_4  output  1  write strobe for one result word.
REQ-013 SHALL have port result_data_out  output  256  result word, same lane packing.
REQ-014 SHALL have port result_mem_counter  output  32  word index of the word being written.
REQ-015 SHALL have port busy  output  1  pass in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of pass.

Function
REQ-017 SHALL implement states IDLE, WAIT, CAPTURE, DRAIN.
REQ-018 In IDLE, on start, SHALL latch n_words = total>>3, alpha, and subtract; remainder elements are ignored.
REQ-019 In IDLE, on start with n_words==0, SHALL stay in IDLE and pulse done in the next cycle, with no read_again and no writes.
REQ-020 In IDLE, on start with n_words>0, SHALL go to WAIT; busy is high from WAIT until done.
REQ-021 WAIT SHALL last one cycle, then go to CAPTURE.
REQ-022 In CAPTURE, read_again SHALL be high; inputs are sampled at the edge ending CAPTURE and rd_cnt increments.
REQ-023 CAPTURE SHALL go to WAIT if rd_cnt+1 < n_words, else to DRAIN; throughput is one word per 2 cycles.
REQ-024 read_again SHALL be asserted exactly n_words times per pass, including for the last word.
REQ-025 Pipeline stage 1, at the capture edge +1, SHALL form the per-lane 64-bit signed product alpha*p.
REQ-026 Pipeline stage 2, at the capture edge +2, SHALL register per lane x ± (product >>> 16).
REQ-027 Stage 2 SHALL saturate each lane to 0x7FFFFFFF / 0x80000000 on overflow.
REQ-028 result_mem_we_4 SHALL be high for exactly one cycle per word, concurrent with result_data_out and result_mem_counter (0..n_words-1, ascending).
REQ-029 DRAIN SHALL wait for the pipeline to empty.
REQ-030 After DRAIN, done SHALL pulse in the cycle after the last result_mem_we_4 cycle, busy SHALL drop with it, and the state returns to IDLE.
REQ-031 start while busy SHALL be ignored, and latched operands SHALL not change.
REQ-032 result_data_out and result_mem_counter SHALL hold their last values when result_mem_we_4 is low.

Reset
REQ-033 On reset SHALL go to IDLE and clear: read_again, result_mem_we_4, busy, done, result_data_out, result_mem_counter, rd_cnt, pipeline valid bits.
REQ-034 Reset asserted mid-pass SHALL abort the pass: no further result_mem_we_4 and no done pulse; reset takes priority over start in the same cycle.

Verification
REQ-035 total=16, alpha=0x00010000, subtract=0, all x lanes 0x00010000, p lanes 0x00020000 -> two writes, all lanes 0x00030000, counters 0 then 1, two read_again pulses, one done.
REQ-036 total=8, alpha=0x00008000, subtract=1, x=0x00010000, p=0x00010000 -> one write, all lanes 0x00008000.
REQ-037 total=8, alpha=0x00010000, x=0x7FFF0000, p=0x00010000 -> lanes 0x7FFFFFFF; with subtract=1, x=0x80010000, p=0x00020000 -> lanes 0x80000000.
REQ-038 total=7, start -> done high the next cycle, read_again and result_mem_we_4 never high.
REQ-039 total=32, reset during the third CAPTURE -> at most two writes observed, all outputs 0 the cycle after reset, then a fresh start completes normally.
REQ-040 total=16, second start pulse during WAIT -> exactly two writes and one done.
